// File: rtl/edge_det_pkg.sv
// Shared types and defaults for the edge detector bank.
// Optional debounce counters: define EDGE_DETECTOR_BANK_DEBOUNCE_EN.
package edge_det_pkg;

  typedef enum logic [1:0] {
    EDGE_OFF  = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 4;

  // rise=1 means the filtered level is about to go 0->1
  function automatic logic edge_hit(
    input edge_mode_t m,
    input logic       rise
  );
    logic hit;
    unique case (m)
      EDGE_RISE: hit = rise;
      EDGE_FALL: hit = !rise;
      EDGE_BOTH: hit = 1'b1;
      default:   hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/edge_det_channel.sv
// One channel: synchroniser, debounce filter, edge pulse, sticky pending.
// Debounce counter present only with EDGE_DETECTOR_BANK_DEBOUNCE_EN.
module edge_det_channel
  import edge_det_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF
`ifdef EDGE_DETECTOR_BANK_DEBOUNCE_EN
  ,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
`endif
) (
  input  logic       clk,
  input  logic       nrst,
  input  logic       en,
  input  logic       in,
  input  edge_mode_t mode,
  input  logic       clr,
  output logic       level,
  output logic       pulse,
  output logic       pending
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  logic                   upd;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], in};
    end
  end

`ifdef EDGE_DETECTOR_BANK_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt;

  assign upd = en && (s != level) &&
               (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  // Any agreement or disable restarts the qualification window
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (!en || (s == level) || upd) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
`else
  assign upd = en && (s != level);
`endif

  // Set beats clear so an edge landing with clr is never lost
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      level   <= 1'b0;
      pulse   <= 1'b0;
      pending <= 1'b0;
    end else begin
      if (upd) begin
        level <= s;
      end
      pulse   <= upd && edge_hit(mode, s);
      pending <= pulse | (pending & ~clr);
    end
  end

endmodule

// File: rtl/edge_detector_bank.sv
// Multi-channel debounced edge detector with aggregated interrupt.
// Debounce counters enabled by defining EDGE_DETECTOR_BANK_DEBOUNCE_EN.
module edge_detector_bank
  import edge_det_pkg::*;
#(
  parameter int CHANNELS        = 4,
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic [CHANNELS-1:0]   en,
  input  logic [CHANNELS-1:0]   in,
  input  logic [2*CHANNELS-1:0] mode,
  input  logic [CHANNELS-1:0]   clr,
  output logic [CHANNELS-1:0]   level,
  output logic [CHANNELS-1:0]   pulse,
  output logic [CHANNELS-1:0]   pending,
  output logic                  irq
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_det_channel #(
      .SYNC_STAGES     (SYNC_STAGES)
`ifdef EDGE_DETECTOR_BANK_DEBOUNCE_EN
      ,
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
`endif
    ) u_ch (
      .clk     (clk),
      .nrst    (nrst),
      .en      (en[i]),
      .in      (in[i]),
      .mode    (edge_mode_t'(mode[2*i +: 2])),
      .clr     (clr[i]),
      .level   (level[i]),
      .pulse   (pulse[i]),
      .pending (pending[i])
    );
  end

  assign irq = |pending;

endmodule

// File: tb/tb_edge_detector_bank.sv
// Self-checking bench for edge_detector_bank, either debounce build
// (EDGE_DETECTOR_BANK_DEBOUNCE_EN defined or not).
module tb_edge_detector_bank;
  import edge_det_pkg::*;

`ifdef EDGE_DETECTOR_BANK_DEBOUNCE_EN
  localparam int DB = 4;
`else
  localparam int DB = 1;
`endif
  localparam int NS  = 2;
  localparam int LAT = NS + DB;
  localparam int CH  = 4;

  logic          clk = 1'b0;
  logic          nrst = 1'b1;
  logic [CH-1:0] en, in, clr;
  logic [2*CH-1:0] mode;
  logic [CH-1:0] level, pulse, pending;
  logic          irq;

  always #50 clk = ~clk;

  edge_detector_bank #(
    .CHANNELS        (CH),
    .SYNC_STAGES     (NS),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .en      (en),
    .in      (in),
    .mode    (mode),
    .clr     (clr),
    .level   (level),
    .pulse   (pulse),
    .pending (pending),
    .irq     (irq)
  );

  int errors = 0;
  int checks = 0;
  int pcnt[CH];

  typedef struct {
    int         ch;
    logic       in_b;
    logic [1:0] md;
    int         cyc;
    logic       lvl;
    int         np;
    logic       pend;
  } vec_t;

  typedef struct {
    int   ch;
    logic lvl;
    int   np;
    logic pend;
  } exp_t;

  vec_t tbl[8];
  exp_t sbq[$];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1 time unit later
  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < CH; i++) pcnt[i] += int'(pulse[i]);
  endtask

  task automatic steps(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    exp_t e;
    tbl[0] = '{1, 1'b1, 2'b01, 3,  (DB == 1), (DB == 1) ? 1 : 0, 1'b0};
    tbl[1] = '{1, 1'b0, 2'b01, 20, 1'b0, 0, (DB == 1)};
    tbl[2] = '{2, 1'b1, 2'b10, 20, 1'b1, 0, 1'b0};
    tbl[3] = '{2, 1'b0, 2'b10, 20, 1'b0, 1, 1'b1};
    tbl[4] = '{2, 1'b1, 2'b11, 20, 1'b1, 1, 1'b1};
    tbl[5] = '{2, 1'b0, 2'b11, 20, 1'b0, 1, 1'b1};
    tbl[6] = '{2, 1'b1, 2'b00, 20, 1'b1, 0, 1'b0};
    tbl[7] = '{2, 1'b0, 2'b00, 20, 1'b0, 0, 1'b0};

    en   = '1;
    in   = '0;
    clr  = '0;
    mode = 8'b11_10_01_01;
    #5 nrst = 1'b0;
    steps(3);
    chk("rst_level", 32'(level), 0);
    chk("rst_pulse", 32'(pulse), 0);
    chk("rst_pending", 32'(pending), 0);
    chk("rst_irq", 32'(irq), 0);
    nrst = 1'b1;
    steps(2);

    // Rising edge latency on channel 0
    in[0] = 1'b1;
    steps(LAT - 1);
    chk("t1_level_early", 32'(level[0]), 0);
    step();
    chk("t1_level", 32'(level[0]), 1);
    chk("t1_pulse", 32'(pulse[0]), 1);
    step();
    chk("t1_pulse_drop", 32'(pulse[0]), 0);
    chk("t1_pending", 32'(pending[0]), 1);
    chk("t1_irq", 32'(irq), 1);

    // Falling pulse coinciding with clr: set wins
    mode[1:0] = 2'b11;
    in[0] = 1'b0;
    steps(LAT);
    chk("t4_fall_pulse", 32'(pulse[0]), 1);
    clr[0] = 1'b1;
    step();
    chk("t4_set_wins", 32'(pending[0]), 1);
    chk("t4_irq_held", 32'(irq), 1);
    step();
    chk("t4_cleared", 32'(pending[0]), 0);
    chk("t4_irq_low", 32'(irq), 0);
    clr[0] = 1'b0;
    steps(3);

    // Glitch filter and mode table
    for (int v = 0; v < 8; v++) begin
      in[tbl[v].ch] = tbl[v].in_b;
      mode[2*tbl[v].ch +: 2] = tbl[v].md;
      clr[tbl[v].ch] = 1'b1;
      sbq.push_back('{tbl[v].ch, tbl[v].lvl, tbl[v].np, tbl[v].pend});
      for (int i = 0; i < CH; i++) pcnt[i] = 0;
      step();
      clr = '0;
      steps(tbl[v].cyc - 1);
      e = sbq.pop_front();
      chk($sformatf("v%0d_level", v), 32'(level[e.ch]), 32'(e.lvl));
      chk($sformatf("v%0d_pulses", v), 32'(pcnt[e.ch]), 32'(e.np));
      chk($sformatf("v%0d_pending", v), 32'(pending[e.ch]), 32'(e.pend));
    end

    // Disabled channel ignores activity, then re-debounces afresh
    en[3] = 1'b0;
    pcnt[3] = 0;
    for (int k = 0; k < 50; k++) begin
      if ($urandom_range(0, 2) == 0) in[3] = ~in[3];
      step();
    end
    in[3] = 1'b1;
    steps(5);
    chk("t5_frozen_level", 32'(level[3]), 0);
    chk("t5_no_pulse", 32'(pcnt[3]), 0);
    chk("t5_no_pending", 32'(pending[3]), 0);
    en[3] = 1'b1;
    steps(DB - 1);
    chk("t5_level_wait", 32'(level[3]), 0);
    step();
    chk("t5_level_upd", 32'(level[3]), 1);
    chk("t5_pulse", 32'(pulse[3]), 1);
    step();
    chk("t5_pending", 32'(pending[3]), 1);

    // Asynchronous reset mid-debounce, then restart with input high
    in[0] = 1'b1;
    steps(4);
    nrst = 1'b0;
    in = 4'b0001;
    #1;
    chk("t6_rst_level", 32'(level), 0);
    chk("t6_rst_pulse", 32'(pulse), 0);
    chk("t6_rst_pending", 32'(pending), 0);
    chk("t6_rst_irq", 32'(irq), 0);
    steps(2);
    nrst = 1'b1;
    steps(LAT - 1);
    chk("t6_pulse_early", 32'(pulse[0]), 0);
    step();
    chk("t6_pulse", 32'(pulse[0]), 1);
    chk("t6_level", 32'(level[0]), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
